plane_shifter: RTL and testbench

//   Reads bitplane words out of the MCU data path and serialises them into per-pixel colour

---
 rtl/gstmcu_video_pkg.sv | 24 ++
 rtl/shift_plane.sv | 54 +++++
 rtl/plane_shifter.sv | 141 ++++++++++++++
 tb/tb_plane_shifter.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/gstmcu_video_pkg.sv
// ----------------------------------------------------------------------------
// gstmcu_video_pkg
//   Shared definitions for the video serialiser path.
//   - MODE_* : encodings of the 2-bit plane-count mode field
//   - nplanes(mode) : number of bitplanes per 16-pixel group for a mode
//                     (mode 3 is not a real mode and behaves as 1 plane)
// ----------------------------------------------------------------------------
package gstmcu_video_pkg;

    localparam logic [1:0] MODE_4PL = 2'd0;
    localparam logic [1:0] MODE_2PL = 2'd1;
    localparam logic [1:0] MODE_1PL = 2'd2;

    function automatic logic [2:0] nplanes(input logic [1:0] mode);
        logic [2:0] n;
        case (mode)
            MODE_4PL: n = 3'd4;
            MODE_2PL: n = 3'd2;
            default:  n = 3'd1;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/shift_plane.sv
// ----------------------------------------------------------------------------
// shift_plane
//   One bitplane lane: a holding register written from the load side and a
//   shift register feeding the pixel side.
//   Ports:
//     clock  - system clock
//     reset  - synchronous active-high reset, clears both registers
//     wr     - write din into the holding register
//     din    - plane word
//     xfer   - copy holding register into shift register (MSB consumed now)
//     shift  - shift the shift register left by one
//     clr    - clear the shift register (has priority over xfer/shift)
//     msb    - bit presented for the current pixel: the holding MSB on a
//              transfer cycle, otherwise the shift register MSB
// ----------------------------------------------------------------------------
module shift_plane #(
    parameter int WORD_W = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              wr,
    input  logic [WORD_W-1:0] din,
    input  logic              xfer,
    input  logic              shift,
    input  logic              clr,
    output logic              msb
);

    logic [WORD_W-1:0] hold;
    logic [WORD_W-1:0] sr;

    always_ff @(posedge clock) begin
        if (reset) begin
            hold <= '0;
            sr   <= '0;
        end else begin
            if (wr) begin
                hold <= din;
            end
            // The MSB is emitted on the transfer cycle itself, so the
            // shift register is loaded already advanced by one bit.
            if (clr) begin
                sr <= '0;
            end else if (xfer) begin
                sr <= {hold[WORD_W-2:0], 1'b0};
            end else if (shift) begin
                sr <= {sr[WORD_W-2:0], 1'b0};
            end
        end
    end

    assign msb = xfer ? hold[WORD_W-1] : sr[WORD_W-1];

endmodule

// File: rtl/plane_shifter.sv
// ----------------------------------------------------------------------------
// plane_shifter
//   Serialises bitplane words into per-pixel colour indices.
//   Load side: plane words enter a holding bank via load/load_ready; a group
//   is complete after N words (N from the mode captured with word 0).
//   Pixel side: on each pix_en with de high, one pixel leaves the shift bank,
//   MSB first; at every 16-pixel boundary the holding bank is transferred.
//   Ports:
//     clock      - system clock, all state on posedge
//     reset      - synchronous active-high reset
//     pix_en     - pixel-clock enable strobe
//     de         - display enable, only looked at when pix_en is high
//     mode       - 0: 4 planes, 1: 2 planes, 2/3: 1 plane
//     load       - word strobe, accepted when load && load_ready
//     din        - plane word, plane 0 first within a group
//     load_ready - holding bank can accept a word
//     pixel      - registered colour index, bit p from plane p
//     underrun   - one-cycle pulse: boundary reached with no group ready
// ----------------------------------------------------------------------------
module plane_shifter
    import gstmcu_video_pkg::*;
#(
    parameter int WORD_W = 16,
    parameter int PLANES = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              pix_en,
    input  logic              de,
    input  logic [1:0]        mode,
    input  logic              load,
    input  logic [WORD_W-1:0] din,
    output logic              load_ready,
    output logic [PLANES-1:0] pixel,
    output logic              underrun
);

    localparam int IDX_W = (PLANES > 1) ? $clog2(PLANES) : 1;
    localparam int CNT_W = $clog2(WORD_W);

    logic [IDX_W-1:0] idx;
    logic             hold_full;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       mode_q;

    logic             accept;
    logic             accept_last;
    logic [2:0]       n_cur;
    logic [2:0]       n_grp;
    logic             step;
    logic             blank;
    logic             at_bound;
    logic             do_xfer;
    logic             starve;
    logic             shift_all;

    logic [PLANES-1:0] wr_v;
    logic [PLANES-1:0] xfer_v;
    logic [PLANES-1:0] clr_v;
    logic [PLANES-1:0] msb_v;
    logic [PLANES-1:0] pix_next;

    // Load-side handshake. Word 0 of a group uses the live mode because
    // mode_q is only captured on that very acceptance.
    assign load_ready  = !hold_full;
    assign accept      = load && !hold_full;
    assign n_cur       = (idx == '0) ? nplanes(mode) : nplanes(mode_q);
    assign n_grp       = nplanes(mode_q);
    assign accept_last = (int'(idx) + 1) == int'(n_cur);

    // Pixel-side control. Transfer and load can never coincide: a transfer
    // needs hold_full, which also blocks acceptance.
    assign step      = pix_en && de;
    assign blank     = pix_en && !de;
    assign at_bound  = step && (cnt == '0);
    assign do_xfer   = at_bound && hold_full;
    assign starve    = at_bound && !hold_full;
    assign shift_all = step && (cnt != '0);

    for (genvar p = 0; p < PLANES; p++) begin : g_plane
        // Planes beyond the group's plane count load as zero.
        assign wr_v[p]   = accept && (idx == IDX_W'(p));
        assign xfer_v[p] = do_xfer && (3'(p) < n_grp);
        assign clr_v[p]  = blank || starve || (do_xfer && (3'(p) >= n_grp));

        shift_plane #(
            .WORD_W(WORD_W)
        ) u_plane (
            .clock (clock),
            .reset (reset),
            .wr    (wr_v[p]),
            .din   (din),
            .xfer  (xfer_v[p]),
            .shift (shift_all),
            .clr   (clr_v[p]),
            .msb   (msb_v[p])
        );
    end

    assign pix_next = msb_v & ~clr_v;

    always_ff @(posedge clock) begin
        if (reset) begin
            idx       <= '0;
            hold_full <= 1'b0;
            cnt       <= '0;
            mode_q    <= MODE_4PL;
            pixel     <= '0;
            underrun  <= 1'b0;
        end else begin
            underrun <= starve;

            if (accept) begin
                if (idx == '0) begin
                    mode_q <= mode;
                end
                if (accept_last) begin
                    idx       <= '0;
                    hold_full <= 1'b1;
                end else begin
                    idx <= idx + IDX_W'(1);
                end
            end

            if (do_xfer) begin
                hold_full <= 1'b0;
            end

            // Blanking restarts the group counter so the next active
            // pixel begins a fresh group from its MSB.
            if (blank) begin
                cnt   <= '0;
                pixel <= '0;
            end else if (step) begin
                cnt   <= cnt + CNT_W'(1);
                pixel <= pix_next;
            end
        end
    end

endmodule

// File: tb/tb_plane_shifter.sv
// ----------------------------------------------------------------------------
// tb_plane_shifter
//   Table-driven group vectors, hand-written corner sequences and random
//   stimulus, all checked every cycle against a group-level reference model.
// ----------------------------------------------------------------------------
module tb_plane_shifter;

    logic        clock = 1'b0;
    logic        reset;
    logic        pix_en;
    logic        de;
    logic [1:0]  mode;
    logic        load;
    logic [15:0] din;
    logic        load_ready;
    logic [3:0]  pixel;
    logic        underrun;

    always #5 clock = ~clock;

    plane_shifter #(
        .WORD_W(16),
        .PLANES(4)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .pix_en     (pix_en),
        .de         (de),
        .mode       (mode),
        .load       (load),
        .din        (din),
        .load_ready (load_ready),
        .pixel      (pixel),
        .underrun   (underrun)
    );

    int vec = 0;
    int bad = 0;

    // Reference model: words of the pending group, and the current group as
    // a precomputed list of 16 colour indices.
    logic        m_full;
    int          m_idx;
    int          m_nq;
    logic [15:0] m_w [4];
    logic [3:0]  m_cur [16];
    int          m_cnt;
    logic [3:0]  e_pix;
    logic        e_und;

    function automatic int np(input logic [1:0] md);
        if (md == 2'd0) return 4;
        if (md == 2'd1) return 2;
        return 1;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vec++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    task automatic model_step();
        logic acc;
        if (reset) begin
            m_full = 1'b0;
            m_idx  = 0;
            m_nq   = 4;
            m_cnt  = 0;
            for (int p = 0; p < 4; p++) m_w[p] = '0;
            for (int i = 0; i < 16; i++) m_cur[i] = '0;
            e_pix = '0;
            e_und = 1'b0;
        end else begin
            acc   = load && !m_full;
            e_und = 1'b0;
            if (pix_en && !de) begin
                m_cnt = 0;
                for (int i = 0; i < 16; i++) m_cur[i] = '0;
                e_pix = '0;
            end else if (pix_en) begin
                if (m_cnt == 0) begin
                    for (int i = 0; i < 16; i++) begin
                        m_cur[i] = '0;
                        if (m_full)
                            for (int p = 0; p < m_nq; p++) m_cur[i][p] = m_w[p][15-i];
                    end
                    if (m_full) m_full = 1'b0;
                    else        e_und  = 1'b1;
                end
                e_pix = m_cur[m_cnt];
                m_cnt = (m_cnt + 1) % 16;
            end
            if (acc) begin
                if (m_idx == 0) m_nq = np(mode);
                m_w[m_idx] = din;
                if (m_idx == m_nq - 1) begin
                    m_idx  = 0;
                    m_full = 1'b1;
                end else begin
                    m_idx++;
                end
            end
        end
    endtask

    task automatic step(input logic r, input logic ld, input logic [15:0] d,
                        input logic pe, input logic dv, input logic [1:0] md);
        reset  = r;
        load   = ld;
        din    = d;
        pix_en = pe;
        de     = dv;
        mode   = md;
        model_step();
        @(posedge clock);
        #1;
        chk("pixel", pixel, e_pix);
        chk("underrun", underrun, e_und);
        chk("load_ready", load_ready, !m_full);
    endtask

    typedef struct packed {
        logic [1:0]       md;
        logic [3:0][15:0] w;
        logic [3:0]       first;
        logic [3:0]       last;
        logic [2:0]       nw;
    } vec_t;

    function automatic vec_t mk(input logic [1:0] md, input logic [15:0] w0, input logic [15:0] w1,
                                input logic [15:0] w2, input logic [15:0] w3,
                                input logic [3:0] first, input logic [3:0] last, input logic [2:0] nw);
        vec_t v;
        v.md = md;
        v.w[0] = w0; v.w[1] = w1; v.w[2] = w2; v.w[3] = w3;
        v.first = first;
        v.last  = last;
        v.nw    = nw;
        return v;
    endfunction

    vec_t tbl [6];

    initial begin
        int n;
        tbl[0] = mk(2'd0, 16'hFFFF, 16'h0000, 16'hFFFF, 16'h0000, 4'h5, 4'h5, 3'd4);
        tbl[1] = mk(2'd2, 16'h8001, 16'h0000, 16'h0000, 16'h0000, 4'h1, 4'h1, 3'd1);
        tbl[2] = mk(2'd1, 16'hA5A5, 16'h0F0F, 16'h0000, 16'h0000, 4'h1, 4'h3, 3'd2);
        tbl[3] = mk(2'd3, 16'h0001, 16'hFFFF, 16'hFFFF, 16'hFFFF, 4'h0, 4'h1, 3'd1);
        tbl[4] = mk(2'd0, 16'h1234, 16'h8000, 16'hFFFF, 16'h0001, 4'h6, 4'hC, 3'd4);
        tbl[5] = mk(2'd1, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 4'h3, 4'h3, 3'd2);

        // Table-driven groups
        for (int t = 0; t < 6; t++) begin
            step(1, 0, 16'h0, 0, 1, 2'd0);
            step(1, 0, 16'h0, 0, 1, 2'd0);
            chk("reset_pixel", pixel, 4'h0);
            chk("reset_ready", load_ready, 1'b1);
            n = 0;
            for (int k = 0; k < 4; k++) begin
                if (!load_ready) break;
                step(0, 1, tbl[t].w[k], 0, 1, tbl[t].md);
                n++;
            end
            chk("words_to_full", n, tbl[t].nw);
            chk("ready_when_full", load_ready, 1'b0);
            for (int i = 0; i < 16; i++) begin
                step(0, 0, 16'h0, 1, 1, tbl[t].md);
                if (i == 0)  chk("first_pixel", pixel, tbl[t].first);
                if (i == 15) chk("last_pixel", pixel, tbl[t].last);
                step(0, 0, 16'h0, 0, 1, tbl[t].md);
            end
            step(0, 0, 16'h0, 1, 1, tbl[t].md);
            chk("underrun_pulse", underrun, 1'b1);
            chk("underrun_pixel", pixel, 4'h0);
            step(0, 0, 16'h0, 0, 1, tbl[t].md);
            chk("underrun_one_cycle", underrun, 1'b0);
        end

        // Loads while full are ignored; first word after transfer is plane 0
        step(1, 0, 16'h0, 0, 1, 2'd2);
        step(0, 1, 16'hC000, 0, 1, 2'd2);
        for (int i = 0; i < 3; i++) step(0, 1, 16'h1111, 0, 1, 2'd2);
        step(0, 1, 16'h1111, 1, 1, 2'd2);
        chk("t4_xfer_pixel", pixel, 4'h1);
        step(0, 1, 16'h8000, 0, 1, 2'd2);
        chk("t4_ready_after_reload", load_ready, 1'b0);
        for (int i = 1; i < 16; i++) begin
            step(0, 1, 16'h7777, 1, 1, 2'd2);
            if (i == 1) chk("t4_second_pixel", pixel, 4'h1);
        end
        step(0, 0, 16'h0, 1, 1, 2'd2);
        chk("t4_next_group_msb", pixel, 4'h1);
        step(0, 0, 16'h0, 1, 1, 2'd2);
        chk("t4_next_group_bit14", pixel, 4'h0);

        // de dropped mid-group, next group preloaded during blanking
        step(1, 0, 16'h0, 0, 1, 2'd0);
        for (int k = 0; k < 4; k++) step(0, 1, 16'hFFFF, 0, 1, 2'd0);
        for (int i = 0; i < 7; i++) step(0, 0, 16'h0, 1, 1, 2'd0);
        chk("t5_active", pixel, 4'hF);
        step(0, 0, 16'h0, 1, 0, 2'd0);
        chk("t5_blank_pixel", pixel, 4'h0);
        chk("t5_blank_no_underrun", underrun, 1'b0);
        step(0, 1, 16'h0000, 0, 0, 2'd0);
        step(0, 1, 16'hFFFF, 1, 0, 2'd0);
        step(0, 1, 16'h0000, 0, 0, 2'd0);
        step(0, 1, 16'h0000, 1, 0, 2'd0);
        step(0, 0, 16'h0, 1, 1, 2'd0);
        chk("t5_restart_msb", pixel, 4'h2);
        chk("t5_restart_no_underrun", underrun, 1'b0);

        // Reset mid-group discards the partial group
        step(1, 0, 16'h0, 0, 1, 2'd0);
        step(0, 1, 16'hAAAA, 0, 1, 2'd0);
        step(0, 1, 16'h5555, 0, 1, 2'd0);
        step(1, 0, 16'h0, 0, 1, 2'd0);
        chk("t6_ready", load_ready, 1'b1);
        chk("t6_pixel", pixel, 4'h0);
        chk("t6_underrun", underrun, 1'b0);
        step(0, 1, 16'h8000, 0, 1, 2'd2);
        chk("t6_single_word_full", load_ready, 1'b0);
        step(0, 0, 16'h0, 1, 1, 2'd2);
        chk("t6_plane0_pixel", pixel, 4'h1);

        // Random traffic against the model
        for (int c = 0; c < 4000; c++) begin
            step($urandom_range(0, 299) == 0,
                 $urandom_range(0, 2) != 0,
                 16'($urandom),
                 $urandom_range(0, 2) == 0,
                 $urandom_range(0, 15) != 0,
                 2'($urandom_range(0, 3)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
        $finish;
    end

endmodule
